a2_bridge_emu: RTL and testbench

Bench-side and bring-up model of the Apple II motherboard plus A2Bridge mux. It is the responder end of the bridge protocol that the card's bus interface initiates. From `clk_logic` it synthesizes `a2_phi1`, `a2_7M` and `a2_reset_n`, and executes host-queued bus cycles one per phi period. It answers the card's multiplexed bridge reads (address lo/hi, data, control) and captures bytes the card drives back, reporting each completed cycle on a response port.

---
 rtl/a2_bridge_emu.sv | 227 ++++++++++++++++++++++
 tb/tb_a2_bridge_emu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2_bridge_emu.sv
// a2_bridge_emu: responder-side model of an Apple II motherboard behind the A2Bridge mux.
// Synthesizes phi1/7M/reset from clk_logic, runs host-queued bus cycles one per phi period,
// answers the card's multiplexed bridge reads and reports every completed cycle.
// Ports:
//   clk_logic, device_reset_n (sync, active low), reset_req (restart a2_reset_n hold)
//   cmd_valid/cmd_ready + cmd_addr/cmd_rw_n/cmd_data : cycle queue input
//   a2_phi1, a2_7M, a2_reset_n                       : synthesized motherboard signals
//   a2_bridge_sel/bus_a_oe/bus_d_oe/rd/wr/d_i         : card-side bridge strobes (active low)
//   a2_bridge_d_o/a2_bridge_d_oe                      : byte returned to the card
//   rsp_valid/rsp_addr/rsp_rw_n/rsp_data/rsp_card_drove/rsp_conflict : completed-cycle report
module a2_bridge_emu #(
    parameter int unsigned M7_HALF          = 4,
    parameter int unsigned PHI_HALF_7M      = 7,
    parameter int unsigned RESET_PHI_CYCLES = 8,
    parameter logic [15:0] IDLE_ADDR        = 16'hFFFF
) (
    input  logic        clk_logic,
    input  logic        device_reset_n,
    input  logic        reset_req,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic        cmd_rw_n,
    input  logic [7:0]  cmd_data,
    output logic        a2_phi1,
    output logic        a2_7M,
    output logic        a2_reset_n,
    input  logic [1:0]  a2_bridge_sel,
    input  logic        a2_bridge_bus_a_oe,
    input  logic        a2_bridge_bus_d_oe,
    input  logic        a2_bridge_rd,
    input  logic        a2_bridge_wr,
    input  logic [7:0]  a2_bridge_d_i,
    output logic [7:0]  a2_bridge_d_o,
    output logic        a2_bridge_d_oe,
    output logic        rsp_valid,
    output logic [15:0] rsp_addr,
    output logic        rsp_rw_n,
    output logic [7:0]  rsp_data,
    output logic        rsp_card_drove,
    output logic        rsp_conflict
);

    localparam int unsigned M7_W  = (M7_HALF > 1) ? $clog2(M7_HALF) : 1;
    localparam int unsigned H_W   = (PHI_HALF_7M > 1) ? $clog2(PHI_HALF_7M) : 1;
    localparam int unsigned RST_W = $clog2(RESET_PHI_CYCLES + 1);
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw_n;
        logic [7:0]  data;
    } cmd_t;

    logic [M7_W-1:0]  m7_cnt_q, m7_cnt_d;
    logic [H_W-1:0]   half_cnt_q, half_cnt_d;
    logic             m7_q, m7_d, phi_q, phi_d, rst_n_q, rst_n_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    cmd_t             fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    cmd_t             cur_q, cur_d;
    logic             active_q, active_d, drove_q, drove_d, conflict_q, conflict_d;
    logic [7:0]       cap_q, cap_d;
    logic             d_oe_q, d_oe_d;
    logic [7:0]       d_o_q, d_o_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_drove_q, rsp_drove_d;
    logic             rsp_conflict_q, rsp_conflict_d;
    cmd_t             rsp_q, rsp_d;

    logic             m7_wrap, half_wrap, phi_rise, push, pop, cap_hit;
    logic             drove_eff, conflict_eff, sel_oe_n;
    logic [7:0]       cap_eff, wdata, sel_byte;

    // Next-state for clocks, queue, cycle tracking, reset hold and bridge responder
    always_comb begin
        m7_wrap   = (m7_cnt_q == M7_W'(M7_HALF - 1));
        half_wrap = m7_wrap && (half_cnt_q == H_W'(PHI_HALF_7M - 1));
        phi_rise  = half_wrap && !phi_q;
        push      = cmd_valid && ready_q;
        pop       = phi_rise && (count_q != '0);

        m7_cnt_d   = m7_wrap ? '0 : m7_cnt_q + M7_W'(1);
        m7_d       = m7_q ^ m7_wrap;
        half_cnt_d = half_cnt_q;
        if (m7_wrap) begin
            half_cnt_d = half_wrap ? '0 : half_cnt_q + H_W'(1);
        end
        phi_d = phi_q ^ half_wrap;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ready_d  = (count_d < CNT_W'(DEPTH));

        // Card drives the data group during phi0; the last drive in the half wins
        cap_hit      = !a2_bridge_wr && (a2_bridge_sel == 2'd2) && !phi_q && active_q;
        drove_eff    = drove_q || cap_hit;
        conflict_eff = conflict_q || (cap_hit && !cur_q.rw_n);
        cap_eff      = cap_hit ? a2_bridge_d_i : cap_q;

        cur_d          = cur_q;
        active_d       = active_q;
        drove_d        = drove_eff;
        conflict_d     = conflict_eff;
        cap_d          = cap_eff;
        rsp_valid_d    = 1'b0;
        rsp_d          = rsp_q;
        rsp_drove_d    = rsp_drove_q;
        rsp_conflict_d = rsp_conflict_q;

        // Phi1 rise closes the current cycle and opens the next one
        if (phi_rise) begin
            if (active_q) begin
                rsp_valid_d    = 1'b1;
                rsp_d.addr     = cur_q.addr;
                rsp_d.rw_n     = cur_q.rw_n;
                rsp_d.data     = drove_eff ? cap_eff : (!cur_q.rw_n ? cur_q.data : 8'hFF);
                rsp_drove_d    = drove_eff;
                rsp_conflict_d = conflict_eff;
            end
            cur_d      = pop ? fifo_q[rd_ptr_q] : '{addr: IDLE_ADDR, rw_n: 1'b1, data: 8'hFF};
            active_d   = 1'b1;
            drove_d    = 1'b0;
            conflict_d = 1'b0;
            cap_d      = 8'hFF;
        end

        rst_n_d   = rst_n_q;
        rst_cnt_d = rst_cnt_q;
        if (reset_req) begin
            rst_n_d   = 1'b0;
            rst_cnt_d = '0;
        end else if (phi_rise && !rst_n_q) begin
            if (rst_cnt_q == RST_W'(RESET_PHI_CYCLES)) begin
                rst_n_d = 1'b1;
            end else begin
                rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
        end

        // Byte reflects the cycle/phase that will be current when it is presented
        wdata = (!phi_d && active_d && !cur_d.rw_n) ? cur_d.data : 8'hFF;
        case (a2_bridge_sel)
            2'd0:    sel_byte = cur_d.addr[7:0];
            2'd1:    sel_byte = cur_d.addr[15:8];
            2'd2:    sel_byte = wdata;
            default: sel_byte = {5'b11111, rst_n_d, 1'b1, cur_d.rw_n};
        endcase
        sel_oe_n = (a2_bridge_sel == 2'd2) ? a2_bridge_bus_d_oe : a2_bridge_bus_a_oe;
        d_oe_d   = !a2_bridge_rd && !sel_oe_n;
        d_o_d    = d_oe_d ? sel_byte : d_o_q;
    end

    // State registers
    always_ff @(posedge clk_logic) begin
        if (!device_reset_n) begin
            m7_cnt_q       <= '0;
            half_cnt_q     <= '0;
            m7_q           <= 1'b0;
            phi_q          <= 1'b0;
            rst_n_q        <= 1'b0;
            rst_cnt_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ready_q        <= 1'b0;
            cur_q          <= '0;
            active_q       <= 1'b0;
            drove_q        <= 1'b0;
            conflict_q     <= 1'b0;
            cap_q          <= 8'hFF;
            d_oe_q         <= 1'b0;
            d_o_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_q          <= '0;
            rsp_drove_q    <= 1'b0;
            rsp_conflict_q <= 1'b0;
        end else begin
            m7_cnt_q       <= m7_cnt_d;
            half_cnt_q     <= half_cnt_d;
            m7_q           <= m7_d;
            phi_q          <= phi_d;
            rst_n_q        <= rst_n_d;
            rst_cnt_q      <= rst_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ready_q        <= ready_d;
            cur_q          <= cur_d;
            active_q       <= active_d;
            drove_q        <= drove_d;
            conflict_q     <= conflict_d;
            cap_q          <= cap_d;
            d_oe_q         <= d_oe_d;
            d_o_q          <= d_o_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_q          <= rsp_d;
            rsp_drove_q    <= rsp_drove_d;
            rsp_conflict_q <= rsp_conflict_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk_logic) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: cmd_addr, rw_n: cmd_rw_n, data: cmd_data};
        end
    end

    assign cmd_ready      = ready_q;
    assign a2_phi1        = phi_q;
    assign a2_7M          = m7_q;
    assign a2_reset_n     = rst_n_q;
    assign a2_bridge_d_o  = d_o_q;
    assign a2_bridge_d_oe = d_oe_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_addr       = rsp_q.addr;
    assign rsp_rw_n       = rsp_q.rw_n;
    assign rsp_data       = rsp_q.data;
    assign rsp_card_drove = rsp_drove_q;
    assign rsp_conflict   = rsp_conflict_q;

endmodule

// File: tb/tb_a2_bridge_emu.sv
// tb_a2_bridge_emu: directed bench for a2_bridge_emu with a cycle scoreboard.
// Queued commands are pushed to an expected-cycle queue; every phi1 rise pops the
// model's cycle and compares it against the DUT's response port.
module tb_a2_bridge_emu;

    logic        clk_logic = 1'b0;
    logic        device_reset_n, reset_req, cmd_valid, cmd_ready, cmd_rw_n;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        a2_phi1, a2_7M, a2_reset_n;
    logic [1:0]  a2_bridge_sel;
    logic        a2_bridge_bus_a_oe, a2_bridge_bus_d_oe, a2_bridge_rd, a2_bridge_wr;
    logic [7:0]  a2_bridge_d_i, a2_bridge_d_o;
    logic        a2_bridge_d_oe, rsp_valid, rsp_rw_n, rsp_card_drove, rsp_conflict;
    logic [15:0] rsp_addr;
    logic [7:0]  rsp_data;

    a2_bridge_emu dut (
        .clk_logic          (clk_logic),
        .device_reset_n     (device_reset_n),
        .reset_req          (reset_req),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_rw_n           (cmd_rw_n),
        .cmd_data           (cmd_data),
        .a2_phi1            (a2_phi1),
        .a2_7M              (a2_7M),
        .a2_reset_n         (a2_reset_n),
        .a2_bridge_sel      (a2_bridge_sel),
        .a2_bridge_bus_a_oe (a2_bridge_bus_a_oe),
        .a2_bridge_bus_d_oe (a2_bridge_bus_d_oe),
        .a2_bridge_rd       (a2_bridge_rd),
        .a2_bridge_wr       (a2_bridge_wr),
        .a2_bridge_d_i      (a2_bridge_d_i),
        .a2_bridge_d_o      (a2_bridge_d_o),
        .a2_bridge_d_oe     (a2_bridge_d_oe),
        .rsp_valid          (rsp_valid),
        .rsp_addr           (rsp_addr),
        .rsp_rw_n           (rsp_rw_n),
        .rsp_data           (rsp_data),
        .rsp_card_drove     (rsp_card_drove),
        .rsp_conflict       (rsp_conflict)
    );

    always #5 clk_logic = ~clk_logic;

    typedef struct {
        logic [15:0] addr;
        logic        rw_n;
        logic [7:0]  data;
        logic        drove;
        logic        conflict;
        logic [7:0]  cap;
    } cyc_t;

    cyc_t pend[$];
    cyc_t cur;
    bit   cur_valid;
    bit   in_rst;
    int   t;
    int   checks;
    int   failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, then check the response port
    task automatic step();
        bit   acc, cap, rise, have;
        cyc_t nc, er;
        acc = cmd_valid && (t >= 1) && (pend.size() < 4);
        nc  = '{addr: cmd_addr, rw_n: cmd_rw_n, data: cmd_data, drove: 1'b0, conflict: 1'b0, cap: 8'hFF};
        cap = !a2_bridge_wr && (a2_bridge_sel == 2'd2) && cur_valid && ((t + 1) % 56 >= 1) && ((t + 1) % 56 <= 28);
        @(posedge clk_logic);
        t++;
        if (cap) begin
            cur.cap   = a2_bridge_d_i;
            cur.drove = 1'b1;
            if (!cur.rw_n) cur.conflict = 1'b1;
        end
        rise = (t % 56 == 28);
        have = 1'b0;
        er   = cur;
        if (rise) begin
            have = cur_valid;
            if (pend.size() > 0) cur = pend.pop_front();
            else cur = '{addr: 16'hFFFF, rw_n: 1'b1, data: 8'hFF, drove: 1'b0, conflict: 1'b0, cap: 8'hFF};
            cur_valid = 1'b1;
        end
        if (acc) pend.push_back(nc);
        #1;
        if (have) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_addr", 32'(rsp_addr), 32'(er.addr));
            chk("rsp_rw_n", 32'(rsp_rw_n), 32'(er.rw_n));
            chk("rsp_data", 32'(rsp_data), 32'(er.drove ? er.cap : (!er.rw_n ? er.data : 8'hFF)));
            chk("rsp_drove", 32'(rsp_card_drove), 32'(er.drove));
            chk("rsp_conflict", 32'(rsp_conflict), 32'(er.conflict));
        end else begin
            chk("rsp_idle", 32'(rsp_valid), 32'd0);
        end
    endtask

    task automatic wait_to(input int p);
        do step(); while (t % 56 != p);
    endtask

    task automatic push_cmd(input logic [15:0] a, input logic rw, input logic [7:0] d);
        cmd_addr  = a;
        cmd_rw_n  = rw;
        cmd_data  = d;
        cmd_valid = 1'b1;
        chk("cmd_ready", 32'(cmd_ready), 32'(pend.size() < 4));
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic bread(input logic [1:0] s, input logic [7:0] e, input string tag);
        a2_bridge_sel = s;
        a2_bridge_rd  = 1'b0;
        if (s == 2'd2) a2_bridge_bus_d_oe = 1'b0;
        else a2_bridge_bus_a_oe = 1'b0;
        step();
        chk({tag, "_oe"}, 32'(a2_bridge_d_oe), 32'd1);
        chk(tag, 32'(a2_bridge_d_o), 32'(e));
        step();
        a2_bridge_rd       = 1'b1;
        a2_bridge_bus_a_oe = 1'b1;
        a2_bridge_bus_d_oe = 1'b1;
        step();
        chk({tag, "_oe_off"}, 32'(a2_bridge_d_oe), 32'd0);
    endtask

    task automatic drive(input logic [7:0] d);
        a2_bridge_sel = 2'd2;
        a2_bridge_d_i = d;
        a2_bridge_wr  = 1'b0;
        step();
        step();
        a2_bridge_wr  = 1'b1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_phi1", 32'(a2_phi1), 32'd0);
        chk("rst_7m", 32'(a2_7M), 32'd0);
        chk("rst_a2_reset_n", 32'(a2_reset_n), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_d_oe", 32'(a2_bridge_d_oe), 32'd0);
        chk("rst_d_o", 32'(a2_bridge_d_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_rw_n, rsp_card_drove, rsp_conflict}), 32'd0);
    endtask

    task automatic enter_reset();
        device_reset_n = 1'b0;
        in_rst = 1'b1;
        repeat (4) @(posedge clk_logic);
        #1;
        chk_reset_vals();
    endtask

    task automatic release_reset();
        @(negedge clk_logic);
        device_reset_n = 1'b1;
        in_rst    = 1'b0;
        t         = 0;
        cur_valid = 1'b0;
        pend.delete();
    endtask

    initial begin
        checks = 0; failures = 0; t = 0; cur_valid = 1'b0;
        reset_req = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw_n = 1'b1; cmd_data = '0;
        a2_bridge_sel = '0; a2_bridge_bus_a_oe = 1'b1; a2_bridge_bus_d_oe = 1'b1;
        a2_bridge_rd = 1'b1; a2_bridge_wr = 1'b1; a2_bridge_d_i = '0;

        // Reset values and clock synthesis after release
        enter_reset();
        release_reset();
        while (t < 32) begin
            step();
            if (t == 1)  chk("ready_after_release", 32'(cmd_ready), 32'd1);
            if (t == 3)  chk("7m_pre_rise", 32'(a2_7M), 32'd0);
            if (t == 4)  chk("7m_first_rise", 32'(a2_7M), 32'd1);
            if (t == 27) chk("phi_pre_rise", 32'(a2_phi1), 32'd0);
            if (t == 28) chk("phi_first_rise", 32'(a2_phi1), 32'd1);
            if (t == 32) chk("7m_after_phi", 32'(a2_7M), 32'd0);
        end
        while (t < 84) begin
            step();
            if (t == 55) chk("phi_high_end", 32'(a2_phi1), 32'd1);
            if (t == 56) chk("phi_fall", 32'(a2_phi1), 32'd0);
            if (t == 83) chk("phi_low_end", 32'(a2_phi1), 32'd0);
            if (t == 84) chk("phi_second_rise", 32'(a2_phi1), 32'd1);
        end
        while (t < 100) step();
        bread(2'd3, 8'hFB, "ctl_in_hold");
        while (t < 475) step();
        chk("a2_reset_hold_last", 32'(a2_reset_n), 32'd0);
        step();
        chk("a2_reset_release", 32'(a2_reset_n), 32'd1);

        // Idle reads
        bread(2'd0, 8'hFF, "idle_lo");
        bread(2'd1, 8'hFF, "idle_hi");
        bread(2'd3, 8'hFF, "idle_ctl");
        bread(2'd2, 8'hFF, "idle_data");

        // Write cycle, including a read that spans the phi1 rise
        wait_to(29);
        push_cmd(16'hC0B5, 1'b0, 8'hA5);
        wait_to(27);
        bread(2'd0, 8'hB5, "wr_lo_edge");
        bread(2'd1, 8'hC0, "wr_hi");
        wait_to(40);
        bread(2'd2, 8'hFF, "wr_data_phi1");
        bread(2'd3, 8'hFE, "wr_ctl");
        wait_to(5);
        bread(2'd2, 8'hA5, "wr_data_phi0");

        // Card drives a read cycle (last drive wins), then a write cycle (conflict)
        wait_to(29);
        push_cmd(16'hC400, 1'b1, 8'h00);
        wait_to(28);
        wait_to(10);
        drive(8'h77);
        drive(8'h5A);
        wait_to(29);
        push_cmd(16'h1234, 1'b0, 8'h11);
        wait_to(28);
        wait_to(10);
        drive(8'h3C);
        wait_to(28);

        // Queue full and refused push on the pop clock
        wait_to(29);
        push_cmd(16'h2000, 1'b1, 8'h00);
        push_cmd(16'h2001, 1'b0, 8'h22);
        push_cmd(16'h2002, 1'b1, 8'h00);
        push_cmd(16'h2003, 1'b0, 8'h44);
        chk("ready_full", 32'(cmd_ready), 32'(pend.size() < 4));
        cmd_addr = 16'hDEAD; cmd_rw_n = 1'b0; cmd_data = 8'h99; cmd_valid = 1'b1;
        wait_to(28);
        cmd_valid = 1'b0;
        chk("ready_after_pop", 32'(cmd_ready), 32'(pend.size() < 4));
        repeat (5) wait_to(28);

        // reset_req restarts the hold count
        wait_to(40);
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        chk("req_low", 32'(a2_reset_n), 32'd0);
        repeat (5) begin
            wait_to(28);
            chk("req_hold", 32'(a2_reset_n), 32'd0);
        end
        wait_to(40);
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_to(28);
            chk("req_restart_hold", 32'(a2_reset_n), 32'd0);
        end
        wait_to(28);
        chk("req_restart_release", 32'(a2_reset_n), 32'd1);

        // device_reset_n mid-cycle drops the in-flight and queued cycles
        wait_to(29);
        push_cmd(16'hBEEF, 1'b0, 8'h42);
        push_cmd(16'h1111, 1'b1, 8'h00);
        wait_to(28);
        wait_to(40);
        enter_reset();
        release_reset();
        wait_to(28);
        wait_to(28);
        wait_to(29);
        push_cmd(16'h5555, 1'b1, 8'h00);
        wait_to(28);
        wait_to(28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
